osc_detect_multi: RTL and testbench
===================================

# osc_detect_multi

Multi-channel oscillation detector. It is the parametrised successor of the single-channel case1/case2 oscillation FSM. Each of `CH` independent channels tracks whether its input bit alternates on every enabled sample. It counts consecutive alternations and flags a channel as oscillating once the count reaches `THRESH`. It sits behind input synchronisers and feeds status/interrupt logic through per-channel sticky flags and a global OR.

## Interface
- `CH`, 4, number of independent channels (≥1)
- `CNT_W`, 4, alternation counter width per channel
- `THRESH`, 4, alternations required to assert `y`; legal range 1..2^CNT_W−1, elaboration error otherwise

- `clk` input 1: single clock, all logic rising-edge
- `rst` input 1: reset, synchronous and active-low
- `en` input 1: sample enable, common to all channels
- `a` input CH: per-channel sampled input bit
- `clr` input 1: clears all sticky flags
- `y` output CH: channel currently oscillating (count ≥ THRESH)
- `sticky` output CH: latched `y`, held until `clr`
- `any_y` output 1: OR of `y`
- `run_cnt` output CH*CNT_W: per-channel alternation count; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Per-channel FSM states:
  - IDLE: no valid previous sample.
  - CASE1: last sample was 0.
  - CASE2: last sample was 1.
- All transitions below occur only on an edge with `en`=1. With `en`=0, state, count, `y` and `sticky` hold. `clr` still acts when `en`=0.
- IDLE, a=0 → CASE1, cnt=0. IDLE, a=1 → CASE2, cnt=0.
- CASE1, a=1 → CASE2, cnt+1. CASE1, a=0 → CASE1, cnt=0.
- CASE2, a=0 → CASE1, cnt+1. CASE2, a=1 → CASE2, cnt=0.
- Count saturates at 2^CNT_W−1. It never wraps.
- `y[i]` is registered and equals (next cnt ≥ THRESH), computed on the same edge as the count update.
- `sticky[i]`:
  - Set on any edge where the new `y[i]` is 1.
  - Cleared by `clr`=1.
  - If set and clear occur on the same edge, set wins.
- `any_y` is the combinational OR of registered `y`.
- Channels are fully independent. One shared `en` and one shared `clr`.

## Timing
- Reset: `rst`=0 sampled on an edge forces every channel to IDLE, cnt=0, `y`=0, `sticky`=0. `any_y` therefore reads 0 in the following cycle.
  - Reset has priority over `en` and `clr`.
  - Reset mid-sequence discards history. The first enabled sample after release only enters CASE1/CASE2.
- Latency:
  - The sample that produces the THRESH-th consecutive alternation is taken on edge k.
  - `y` and `sticky` are high from edge k and are visible during cycle k+1.
  - A break (repeated value) on edge m drops `y` from edge m.
- Minimum enabled samples to assert from IDLE: THRESH+1.
- No combinational path from `a` or `en` to any output.

## Structure
- Package `osc_pkg`:
  - typedef `osc_state_t` (2-bit enum IDLE=0, CASE1=1, CASE2=2; encoding 3 is unreachable and decodes to IDLE).
  - Shared localparam helper for the saturation value.
- Sub-module `osc_chan`:
  - Holds one channel's FSM, saturating counter, `y` and sticky register.
  - Ports: `clk`, `rst`, `en`, `a`, `clr`, `y`, `sticky`, `cnt`.
  - Instantiated `CH` times in a generate loop.
- Top level contains only the generate loop, `run_cnt` packing and the `any_y` OR.

## Test plan
- Reset: hold `rst`=0 for 2 edges with random `a`/`en` → `y`=0, `sticky`=0, `any_y`=0, all `run_cnt`=0.
- Assert (THRESH=4): ch0 `a`=0,1,0,1,0 on 5 enabled edges → cnt 0,1,2,3,4. `y[0]`=1 after the 5th edge, `sticky[0]`=1, `any_y`=1, other channels 0.
- Break: ch1 `a`=0,1,0,1,1 → cnt 0,1,2,3,0. `y[1]` never asserts. Feeding 0 next gives cnt=1.
- Saturation: CNT_W=4, 20 alternations on ch2 → cnt stops at 15 and `y[2]` stays 1. A then-repeated value gives cnt=0 and `y[2]`=0 while `sticky[2]` stays 1. Then `clr`=1 for one edge → `sticky[2]`=0.
- Enable/clear priority: `en`=0 for 3 edges mid-sequence at cnt=2 → cnt holds 2. Resume and alternate to 4 while `clr`=1 on the asserting edge → `sticky` ends 1.
- Reset mid-operation: ch3 at `y`=1, cnt=6, drive `rst`=0 one edge → all zero. Release, then `a`=1,0 → cnt 0,1.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types and helpers for the multi-channel oscillation detector.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package osc_pkg;

    // Per-channel tracking state; encoding 3 is unreachable and decodes as IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CASE1 = 2'd1,
        CASE2 = 2'd2
    } osc_state_t;

    // Saturation value of a w-bit counter, usable in localparam expressions
    function automatic int sat_val(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/osc_chan.sv
// One channel: alternation FSM, saturating run counter, registered y and sticky flag.
// Latency: y/sticky/cnt update on the edge that takes the sample, visible next cycle.
// Backpressure: none; en=0 freezes state, count and y, clr still acts on sticky.
module osc_chan
    import osc_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             clr,
    output logic             y,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    osc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             sticky_q, sticky_d;

    // Next-state: advance only on enabled samples; y tracks the new count
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        sticky_d = sticky_q;

        if (en) begin
            case (state_q)
                CASE1: begin
                    if (a) begin
                        state_d = CASE2;
                        cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                CASE2: begin
                    if (!a) begin
                        state_d = CASE1;
                        cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                default: begin
                    // No previous sample yet: only record the current level
                    state_d = a ? CASE2 : CASE1;
                    cnt_d   = '0;
                end
            endcase
            y_d = (cnt_d >= THR);
        end

        // Set beats clear when both land on the same edge
        if (clr) begin
            sticky_d = 1'b0;
        end
        if (y_d) begin
            sticky_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            sticky_q <= sticky_d;
        end
    end

    assign y      = y_q;
    assign sticky = sticky_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/osc_detect_multi.sv
// CH independent oscillation detectors with packed run counts and a global OR.
// Latency: one edge from enabled sample to y/sticky/run_cnt; any_y is combinational on registered y.
// Backpressure: none; shared en freezes all channels, shared clr clears all sticky flags.
module osc_detect_multi
    import osc_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CNT_W  = 4,
    parameter int THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH-1:0]       a,
    input  logic                clr,
    output logic [CH-1:0]       y,
    output logic [CH-1:0]       sticky,
    output logic                any_y,
    output logic [CH*CNT_W-1:0] run_cnt
);

    // Threshold must be reachable by the saturating counter and non-zero
    if (THRESH < 1 || THRESH > sat_val(CNT_W)) begin : g_bad_thresh
        $error("osc_detect_multi: THRESH out of range 1..2^CNT_W-1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        osc_chan #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .a      (a[i]),
            .clr    (clr),
            .y      (y[i]),
            .sticky (sticky[i]),
            .cnt    (run_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign any_y = |y;

endmodule

// File: tb/tb_osc_detect_multi.sv
// Self-checking bench for osc_detect_multi: directed scenarios plus random traffic.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_osc_detect_multi;

    localparam int CH     = 4;
    localparam int CNT_W  = 4;
    localparam int THRESH = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [CH-1:0]       a;
    logic                clr;
    logic [CH-1:0]       y;
    logic [CH-1:0]       sticky;
    logic                any_y;
    logic [CH*CNT_W-1:0] run_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per channel, whether a previous sample exists, its
    // value, the current run of alternations, and the two flags.
    bit m_have [CH];
    bit m_prev [CH];
    int m_run  [CH];
    bit m_y    [CH];
    bit m_st   [CH];

    osc_detect_multi #(
        .CH     (CH),
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .clr     (clr),
        .y       (y),
        .sticky  (sticky),
        .any_y   (any_y),
        .run_cnt (run_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int ch);
        return int'(run_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic model_update(input bit e, input logic [CH-1:0] av, input bit c, input bit r);
        for (int i = 0; i < CH; i++) begin
            if (!r) begin
                m_have[i] = 0;
                m_prev[i] = 0;
                m_run[i]  = 0;
                m_y[i]    = 0;
                m_st[i]   = 0;
            end else begin
                if (e) begin
                    if (!m_have[i])              m_run[i] = 0;
                    else if (av[i] != m_prev[i]) m_run[i] = (m_run[i] < SAT) ? m_run[i] + 1 : SAT;
                    else                         m_run[i] = 0;
                    m_have[i] = 1;
                    m_prev[i] = av[i];
                    m_y[i]    = (m_run[i] >= THRESH);
                end
                if (m_y[i])  m_st[i] = 1;
                else if (c)  m_st[i] = 0;
            end
        end
    endtask

    task automatic compare_model();
        logic [CH-1:0] ey, es;
        for (int i = 0; i < CH; i++) begin
            ey[i] = m_y[i];
            es[i] = m_st[i];
            check_eq($sformatf("cnt%0d", i), 32'(cnt_of(i)), 32'(m_run[i]));
        end
        check_eq("y", 32'(y), 32'(ey));
        check_eq("sticky", 32'(sticky), 32'(es));
        check_eq("any_y", 32'(any_y), 32'(|ey));
    endtask

    // Drive one cycle, advance the model on the same edge, then compare
    task automatic step(input bit e, input logic [CH-1:0] av, input bit c, input bit r);
        en  = e;
        a   = av;
        clr = c;
        rst = r;
        @(posedge clk);
        model_update(e, av, c, r);
        #1;
        compare_model();
    endtask

    initial begin
        logic [CH-1:0] av;
        int            v;
        int            b0 [5];
        int            b1 [6];
        int            e1 [6];

        rst = 1'b0; en = 1'b0; clr = 1'b0; a = '0;
        for (int i = 0; i < CH; i++) begin
            m_have[i] = 0; m_prev[i] = 0; m_run[i] = 0; m_y[i] = 0; m_st[i] = 0;
        end

        // Reset held two edges with random inputs
        repeat (2) step(1'($urandom), CH'($urandom), 1'($urandom), 1'b0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_sticky", 32'(sticky), 32'd0);
        check_eq("rst_any", 32'(any_y), 32'd0);
        check_eq("rst_cnt", 32'(run_cnt), 32'd0);

        // Assert on ch0 after THRESH+1 enabled samples
        b0 = '{0, 1, 0, 1, 0};
        for (int k = 0; k < 5; k++) begin
            av = '0;
            av[0] = b0[k][0];
            step(1'b1, av, 1'b0, 1'b1);
            check_eq($sformatf("asr_cnt0_%0d", k), 32'(cnt_of(0)), 32'(k));
        end
        check_eq("asr_y", 32'(y), 32'b0001);
        check_eq("asr_sticky", 32'(sticky), 32'b0001);
        check_eq("asr_any", 32'(any_y), 32'd1);

        // Break on ch1: repeated value resets the run
        b1 = '{0, 1, 0, 1, 1, 0};
        e1 = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            av = '0;
            av[1] = b1[k][0];
            step(1'b1, av, 1'b0, 1'b1);
            check_eq($sformatf("brk_cnt1_%0d", k), 32'(cnt_of(1)), 32'(e1[k]));
            check_eq($sformatf("brk_y1_%0d", k), 32'(y[1]), 32'd0);
        end
        check_eq("brk_sticky0_held", 32'(sticky[0]), 32'd1);

        // Saturation on ch2
        for (int k = 0; k < 20; k++) begin
            av = '0;
            av[2] = (k % 2 == 0);
            step(1'b1, av, 1'b0, 1'b1);
        end
        check_eq("sat_cnt2", 32'(cnt_of(2)), 32'd15);
        check_eq("sat_y2", 32'(y[2]), 32'd1);
        step(1'b1, '0, 1'b0, 1'b1);
        check_eq("sat_brk_cnt2", 32'(cnt_of(2)), 32'd0);
        check_eq("sat_brk_y2", 32'(y[2]), 32'd0);
        check_eq("sat_brk_st2", 32'(sticky[2]), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        check_eq("clr_sticky", 32'(sticky), 32'd0);

        // Enable hold and set-over-clear on ch3
        step(1'b1, 4'b1000, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check_eq("en_cnt3_pre", 32'(cnt_of(3)), 32'd2);
        repeat (3) step(1'b0, CH'($urandom), 1'b0, 1'b1);
        check_eq("en_cnt3_hold", 32'(cnt_of(3)), 32'd2);
        step(1'b1, 4'b1000, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        check_eq("setclr_cnt3", 32'(cnt_of(3)), 32'd4);
        check_eq("setclr_st3", 32'(sticky[3]), 32'd1);
        step(1'b1, 4'b1000, 1'b0, 1'b1);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check_eq("mid_cnt3", 32'(cnt_of(3)), 32'd6);
        check_eq("mid_y3", 32'(y[3]), 32'd1);

        // Reset mid-operation discards history
        step(1'b1, 4'b1000, 1'b1, 1'b0);
        check_eq("mrst_cnt", 32'(run_cnt), 32'd0);
        check_eq("mrst_y", 32'(y), 32'd0);
        check_eq("mrst_st", 32'(sticky), 32'd0);
        check_eq("mrst_any", 32'(any_y), 32'd0);
        step(1'b1, 4'b1000, 1'b0, 1'b1);
        check_eq("post_cnt3_a", 32'(cnt_of(3)), 32'd0);
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        check_eq("post_cnt3_b", 32'(cnt_of(3)), 32'd1);

        // Random traffic biased toward alternation
        av = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) begin
                v = $urandom_range(0, 99);
                if (v < 85) av[i] = ~av[i];
            end
            step(($urandom_range(0, 99) < 80), av,
                 ($urandom_range(0, 99) < 8),
                 !($urandom_range(0, 199) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
